latency_stats_tracker: RTL and testbench
========================================

Name: latency_stats_tracker

Overview:
- Multi-tag round-trip latency tracker: TX side stamps the free-running latency counter into a per-tag slot, RX side looks up the tag on return and outputs the latency with a 2-cycle pipeline.
- Keeps min/max/sum/count statistics, plus counts of orphans, duplicates and outstanding tags.
- Sits between TX_ENGINE (stamp) and RX_ENGINE (return) and replaces the raw BRAM timestamp store with on-chip latency computation.

Parameters:
- CNT_WIDTH, 40, width of latency_counter, stored stamps and latency results.
- TAG_WIDTH, 8, tag width; depth = 2**TAG_WIDTH slots.
- ACC_WIDTH, 64, width of stat_sum.
- EVT_WIDTH, 32, width of the stat_count, orphan, duplicate and outstanding counters.

Ports:
- clk  in  1  single clock, 250 MHz.
- rst_n  in  1  asynchronous active-low reset.
- latency_counter  in  CNT_WIDTH  free-running timestamp; wraps modulo 2**CNT_WIDTH.
- stats_clear  in  1  synchronous clear of stats, error counters and all pending bits.
- stamp_valid  in  1  TX stamp request.
- stamp_tag  in  TAG_WIDTH  slot to stamp.
- ret_valid  in  1  RX return event.
- ret_tag  in  TAG_WIDTH  slot returned.
- lat_valid  out  1  one-cycle result strobe.
- lat_tag  out  TAG_WIDTH  tag of the result.
- lat_value  out  CNT_WIDTH  latency in counter ticks; 0 when lat_orphan = 1.
- lat_orphan  out  1  return hit a slot with no pending stamp.
- stat_count  out  EVT_WIDTH  number of valid latencies accumulated.
- stat_sum  out  ACC_WIDTH  sum of valid latencies; saturating.
- stat_min  out  CNT_WIDTH  minimum valid latency.
- stat_max  out  CNT_WIDTH  maximum valid latency.
- orphan_cnt  out  EVT_WIDTH  orphan returns.
- dup_cnt  out  EVT_WIDTH  stamps issued to an already-pending slot.
- outstanding  out  EVT_WIDTH  number of pending slots.

Behaviour:
- Storage:
  - Stamp RAM (depth 2**TAG_WIDTH x CNT_WIDTH) with a 1-cycle synchronous read.
  - Pending bits are held in flops.
- Stamp (cycle t), when stamp_valid = 1:
  - mem[stamp_tag] <= latency_counter; pending[stamp_tag] <= 1.
  - If the slot was already pending: dup_cnt++, the stamp is overwritten, outstanding is unchanged.
  - Otherwise outstanding++.
- Return pipeline:
  - S1, cycle t: when ret_valid = 1, register ret_tag, latency_counter (as ret_ts) and pending[ret_tag]; clear pending[ret_tag]; issue the RAM read.
  - S2, cycle t+1: lat = ret_ts - stamp, computed modulo 2**CNT_WIDTH, so counter wrap is handled naturally.
  - Output, cycle t+2: registered result, lat_valid = 1 for exactly one cycle.
- Result outcomes:
  - Pending hit: lat_orphan = 0, outstanding-- (applied in S1).
  - Non-pending tag: lat_orphan = 1, lat_value = 0, orphan_cnt++, no stats update.
- Statistics update on each non-orphan result, in the lat_valid cycle:
  - stat_count++; stat_sum += lat, saturating at all-ones.
  - stat_min = min(stat_min, lat); stat_max = max(stat_max, lat).
- Simultaneous stamp and return on the same tag in the same cycle:
  - The return is evaluated against the prior state (read-first): it uses the old stamp and old pending bit.
  - The new stamp is then written and pending ends at 1.
  - Net outstanding = prior value - (prior pending ? 1 : 0) + 1.
- Simultaneous stamp and return on different tags: both are processed; outstanding changes by the net amount (+1, -1, or 0).
- Back-to-back returns: one per cycle is accepted with no stall. Returns to the same tag in consecutive cycles: the second is an orphan.
- Event counters (stat_count, orphan_cnt, dup_cnt, outstanding) saturate at all-ones and never wrap.
- stats_clear:
  - Sets stat_count, stat_sum, orphan_cnt, dup_cnt and outstanding to 0, stat_min to all-ones, stat_max to 0, and clears every pending bit.
  - The same-cycle stamp still sets its pending bit, giving outstanding = 1.
  - In-flight S1/S2 results still emit lat_valid, but a result presented in the clear cycle is not accumulated.
- Reset (async, rst_n = 0):
  - lat_valid = 0, lat_tag = 0, lat_value = 0, lat_orphan = 0.
  - stat_count = 0, stat_sum = 0, stat_min = all-ones, stat_max = 0.
  - orphan_cnt = 0, dup_cnt = 0, outstanding = 0; all pending bits = 0.
  - Pipeline valids are cleared and in-flight returns are dropped.
  - RAM contents are not reset and are don't-care, because pending = 0.

Test Plan:
- Stamp tag 5 at counter 100, return tag 5 at counter 350 -> two cycles later lat_valid = 1, lat_tag = 5, lat_value = 250, lat_orphan = 0; stat_count = 1, stat_min = stat_max = 250, stat_sum = 250, outstanding 1->0.
- Wrap: stamp tag 1 at counter 2**40-10, return at counter 5 -> lat_value = 15.
- Orphan and duplicate: return tag 9 never stamped -> lat_orphan = 1, lat_value = 0, orphan_cnt = 1, stats unchanged. Stamp tag 3 twice at 10 and 20, return at 50 -> dup_cnt = 1, lat_value = 30.
- Same-cycle collision: stamp tag 7 at 0, then stamp and return tag 7 together at 40 -> lat_value = 40, pending[7] stays set, outstanding = 1; a later return at 100 gives lat_value = 60.
- Streaming: 256 stamps on tags 0..255, then 256 back-to-back returns with latencies 1..256 -> 256 lat_valid pulses on consecutive cycles, stat_count = 256, stat_min = 1, stat_max = 256, stat_sum = 32896, outstanding = 0.
- Clear and reset: stats_clear while 3 tags are pending -> all counters 0, stat_min = all-ones, a later return on those tags is an orphan. Assert rst_n mid-pipeline -> lat_valid = 0 immediately and no pulse after release.

Source files
------------

// File: rtl/latency_stats_tracker.sv
// Multi-tag round-trip latency tracker.
// TX stamps latency_counter into a per-tag slot. RX looks the tag up and
// produces the latency through a 2-stage pipeline. Alongside it keeps
// min/max/sum/count statistics and counters for orphans, duplicates and
// outstanding tags.
module latency_stats_tracker #(
  parameter int unsigned CNT_WIDTH = 40,
  parameter int unsigned TAG_WIDTH = 8,
  parameter int unsigned ACC_WIDTH = 64,
  parameter int unsigned EVT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT_WIDTH-1:0] latency_counter,
  input  logic                 stats_clear,
  input  logic                 stamp_valid,
  input  logic [TAG_WIDTH-1:0] stamp_tag,
  input  logic                 ret_valid,
  input  logic [TAG_WIDTH-1:0] ret_tag,
  output logic                 lat_valid,
  output logic [TAG_WIDTH-1:0] lat_tag,
  output logic [CNT_WIDTH-1:0] lat_value,
  output logic                 lat_orphan,
  output logic [EVT_WIDTH-1:0] stat_count,
  output logic [ACC_WIDTH-1:0] stat_sum,
  output logic [CNT_WIDTH-1:0] stat_min,
  output logic [CNT_WIDTH-1:0] stat_max,
  output logic [EVT_WIDTH-1:0] orphan_cnt,
  output logic [EVT_WIDTH-1:0] dup_cnt,
  output logic [EVT_WIDTH-1:0] outstanding
);

  localparam int unsigned DEPTH = 1 << TAG_WIDTH;
  localparam logic [EVT_WIDTH-1:0] EVT_ONE = EVT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_WIDTH-1:0] r_rd_stamp;
  logic [DEPTH-1:0]     r_pending;
  logic [DEPTH-1:0]     w_pending_nxt;

  logic                 r_s1_valid;
  logic [TAG_WIDTH-1:0] r_s1_tag;
  logic [CNT_WIDTH-1:0] r_s1_ts;
  logic                 r_s1_pend;

  logic                 r_lat_valid;
  logic [TAG_WIDTH-1:0] r_lat_tag;
  logic [CNT_WIDTH-1:0] r_lat_value;
  logic                 r_lat_orphan;

  logic [EVT_WIDTH-1:0] r_stat_count;
  logic [ACC_WIDTH-1:0] r_stat_sum;
  logic [CNT_WIDTH-1:0] r_stat_min;
  logic [CNT_WIDTH-1:0] r_stat_max;
  logic [EVT_WIDTH-1:0] r_orphan_cnt;
  logic [EVT_WIDTH-1:0] r_dup_cnt;
  logic [EVT_WIDTH-1:0] r_outstanding;

  logic                 w_ret_hit;
  logic                 w_same_tag;
  logic                 w_dup;
  logic                 w_stamp_new;
  logic [CNT_WIDTH-1:0] w_lat;
  logic                 w_stat_upd;
  logic                 w_orph_upd;
  logic [ACC_WIDTH:0]   w_sum_wide;

  // A return hits only if its slot is pending in the prior state. A stamp
  // colliding with a same-tag return re-arms the slot the return consumes,
  // so it counts as a fresh stamp rather than a duplicate.
  assign w_ret_hit   = ret_valid & r_pending[ret_tag];
  assign w_same_tag  = stamp_valid & ret_valid & (stamp_tag == ret_tag);
  assign w_dup       = stamp_valid & r_pending[stamp_tag] & ~w_same_tag;
  assign w_stamp_new = stamp_valid & ~w_dup;

  assign w_lat      = r_s1_ts - r_rd_stamp;
  assign w_stat_upd = r_lat_valid & ~r_lat_orphan & ~stats_clear;
  assign w_orph_upd = r_lat_valid &  r_lat_orphan & ~stats_clear;
  assign w_sum_wide = {1'b0, r_stat_sum} + {{(ACC_WIDTH + 1 - CNT_WIDTH){1'b0}}, r_lat_value};

  // Stamp RAM: write on stamp, synchronous read-first lookup on return.
  always_ff @(posedge clk) begin
    if (stamp_valid) r_mem[stamp_tag] <= latency_counter;
    if (ret_valid)   r_rd_stamp       <= r_mem[ret_tag];
  end

  // Next pending vector: clear, then return clears its bit, then stamp sets (stamp wins).
  always_comb begin
    w_pending_nxt = stats_clear ? '0 : r_pending;
    if (ret_valid && !stats_clear) w_pending_nxt[ret_tag] = 1'b0;
    if (stamp_valid)               w_pending_nxt[stamp_tag] = 1'b1;
  end

  // Pending flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

  // Outstanding and duplicate counters, updated in the stamp/return cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_dup_cnt     <= '0;
    end else if (stats_clear) begin
      r_outstanding <= {{(EVT_WIDTH - 1){1'b0}}, stamp_valid};
      r_dup_cnt     <= '0;
    end else begin
      case ({w_stamp_new, w_ret_hit})
        2'b10:   if (r_outstanding != '1) r_outstanding <= r_outstanding + EVT_ONE;
        2'b01:   r_outstanding <= r_outstanding - EVT_ONE;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_dup && r_dup_cnt != '1) r_dup_cnt <= r_dup_cnt + EVT_ONE;
    end
  end

  // S1: capture the return against the prior pending state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_tag   <= '0;
      r_s1_ts    <= '0;
      r_s1_pend  <= 1'b0;
    end else begin
      r_s1_valid <= ret_valid;
      if (ret_valid) begin
        r_s1_tag  <= ret_tag;
        r_s1_ts   <= latency_counter;
        r_s1_pend <= r_pending[ret_tag];
      end
    end
  end

  // S2: modular latency subtraction into the registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_valid  <= 1'b0;
      r_lat_tag    <= '0;
      r_lat_value  <= '0;
      r_lat_orphan <= 1'b0;
    end else begin
      r_lat_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_lat_tag    <= r_s1_tag;
        r_lat_orphan <= ~r_s1_pend;
        r_lat_value  <= r_s1_pend ? w_lat : '0;
      end
    end
  end

  // Statistics and orphan count, accumulated in the lat_valid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_count <= '0;
      r_stat_sum   <= '0;
      r_stat_min   <= '1;
      r_stat_max   <= '0;
      r_orphan_cnt <= '0;
    end else if (stats_clear) begin
      r_stat_count <= '0;
      r_stat_sum   <= '0;
      r_stat_min   <= '1;
      r_stat_max   <= '0;
      r_orphan_cnt <= '0;
    end else begin
      if (w_stat_upd) begin
        if (r_stat_count != '1) r_stat_count <= r_stat_count + EVT_ONE;
        r_stat_sum <= w_sum_wide[ACC_WIDTH] ? '1 : w_sum_wide[ACC_WIDTH-1:0];
        if (r_lat_value < r_stat_min) r_stat_min <= r_lat_value;
        if (r_lat_value > r_stat_max) r_stat_max <= r_lat_value;
      end
      if (w_orph_upd && r_orphan_cnt != '1) r_orphan_cnt <= r_orphan_cnt + EVT_ONE;
    end
  end

  assign lat_valid   = r_lat_valid;
  assign lat_tag     = r_lat_tag;
  assign lat_value   = r_lat_value;
  assign lat_orphan  = r_lat_orphan;
  assign stat_count  = r_stat_count;
  assign stat_sum    = r_stat_sum;
  assign stat_min    = r_stat_min;
  assign stat_max    = r_stat_max;
  assign orphan_cnt  = r_orphan_cnt;
  assign dup_cnt     = r_dup_cnt;
  assign outstanding = r_outstanding;

endmodule

// File: tb/tb_latency_stats_tracker.sv
// Directed bench for latency_stats_tracker with hand-computed expectations.
module tb_latency_stats_tracker;

  localparam int unsigned CW = 40;
  localparam int unsigned TW = 8;
  localparam int unsigned AW = 64;
  localparam int unsigned EW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] latency_counter = '0;
  logic          stats_clear = 1'b0;
  logic          stamp_valid = 1'b0;
  logic [TW-1:0] stamp_tag = '0;
  logic          ret_valid = 1'b0;
  logic [TW-1:0] ret_tag = '0;
  logic          lat_valid;
  logic [TW-1:0] lat_tag;
  logic [CW-1:0] lat_value;
  logic          lat_orphan;
  logic [EW-1:0] stat_count;
  logic [AW-1:0] stat_sum;
  logic [CW-1:0] stat_min;
  logic [CW-1:0] stat_max;
  logic [EW-1:0] orphan_cnt;
  logic [EW-1:0] dup_cnt;
  logic [EW-1:0] outstanding;

  int unsigned vecs = 0;
  int unsigned errs = 0;
  int unsigned pulses;

  localparam logic [CW-1:0] MIN_RST = '1;

  latency_stats_tracker #(
    .CNT_WIDTH(CW),
    .TAG_WIDTH(TW),
    .ACC_WIDTH(AW),
    .EVT_WIDTH(EW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .latency_counter(latency_counter),
    .stats_clear(stats_clear),
    .stamp_valid(stamp_valid),
    .stamp_tag(stamp_tag),
    .ret_valid(ret_valid),
    .ret_tag(ret_tag),
    .lat_valid(lat_valid),
    .lat_tag(lat_tag),
    .lat_value(lat_value),
    .lat_orphan(lat_orphan),
    .stat_count(stat_count),
    .stat_sum(stat_sum),
    .stat_min(stat_min),
    .stat_max(stat_max),
    .orphan_cnt(orphan_cnt),
    .dup_cnt(dup_cnt),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic stamp(input logic [TW-1:0] tag, input logic [CW-1:0] ts);
    stamp_valid = 1'b1; stamp_tag = tag; latency_counter = ts;
    cyc();
    stamp_valid = 1'b0;
  endtask

  // Issue a return, check the result strobe two cycles later, then step once more.
  task automatic ret_chk(input string name, input logic [TW-1:0] tag, input logic [CW-1:0] ts,
                         input logic [CW-1:0] exp_val, input logic exp_orph);
    ret_valid = 1'b1; ret_tag = tag; latency_counter = ts;
    cyc();
    ret_valid = 1'b0;
    cyc();
    chk({name, ".valid"}, 64'(lat_valid), 64'd1);
    chk({name, ".tag"}, 64'(lat_tag), 64'(tag));
    chk({name, ".value"}, 64'(lat_value), 64'(exp_val));
    chk({name, ".orphan"}, 64'(lat_orphan), 64'(exp_orph));
    cyc();
    chk({name, ".strobe_1cyc"}, 64'(lat_valid), 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.lat_valid", 64'(lat_valid), 64'd0);
    chk("rst.stat_min", 64'(stat_min), 64'(MIN_RST));
    chk("rst.stat_max", 64'(stat_max), 64'd0);
    chk("rst.count", 64'(stat_count), 64'd0);
    chk("rst.outstanding", 64'(outstanding), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Basic round trip: 350 - 100 = 250
    stamp(8'd5, 40'd100);
    chk("basic.outst_up", 64'(outstanding), 64'd1);
    ret_valid = 1'b1; ret_tag = 8'd5; latency_counter = 40'd350;
    cyc();
    ret_valid = 1'b0;
    chk("basic.outst_s1", 64'(outstanding), 64'd0);
    cyc();
    chk("basic.valid", 64'(lat_valid), 64'd1);
    chk("basic.tag", 64'(lat_tag), 64'd5);
    chk("basic.value", 64'(lat_value), 64'd250);
    chk("basic.orphan", 64'(lat_orphan), 64'd0);
    cyc();
    chk("basic.strobe_1cyc", 64'(lat_valid), 64'd0);
    chk("basic.count", 64'(stat_count), 64'd1);
    chk("basic.min", 64'(stat_min), 64'd250);
    chk("basic.max", 64'(stat_max), 64'd250);
    chk("basic.sum", 64'(stat_sum), 64'd250);

    // Counter wrap: 5 - (2^40 - 10) mod 2^40 = 15
    stamp(8'd1, 40'hFF_FFFF_FFF6);
    ret_chk("wrap", 8'd1, 40'd5, 40'd15, 1'b0);
    chk("wrap.count", 64'(stat_count), 64'd2);
    chk("wrap.min", 64'(stat_min), 64'd15);
    chk("wrap.max", 64'(stat_max), 64'd250);
    chk("wrap.sum", 64'(stat_sum), 64'd265);

    // Orphan return on a never-stamped tag
    ret_chk("orphan", 8'd9, 40'd77, 40'd0, 1'b1);
    chk("orphan.cnt", 64'(orphan_cnt), 64'd1);
    chk("orphan.count", 64'(stat_count), 64'd2);
    chk("orphan.sum", 64'(stat_sum), 64'd265);

    // Duplicate stamp: second stamp overwrites, 50 - 20 = 30
    stamp(8'd3, 40'd10);
    stamp(8'd3, 40'd20);
    chk("dup.cnt", 64'(dup_cnt), 64'd1);
    chk("dup.outst", 64'(outstanding), 64'd1);
    ret_chk("dup", 8'd3, 40'd50, 40'd30, 1'b0);
    chk("dup.count", 64'(stat_count), 64'd3);
    chk("dup.sum", 64'(stat_sum), 64'd295);

    // Same-cycle stamp and return on tag 7 (read-first)
    stamp(8'd7, 40'd0);
    stamp_valid = 1'b1; stamp_tag = 8'd7;
    ret_valid = 1'b1; ret_tag = 8'd7; latency_counter = 40'd40;
    cyc();
    stamp_valid = 1'b0; ret_valid = 1'b0;
    chk("coll.outst", 64'(outstanding), 64'd1);
    cyc();
    chk("coll.valid", 64'(lat_valid), 64'd1);
    chk("coll.value", 64'(lat_value), 64'd40);
    chk("coll.orphan", 64'(lat_orphan), 64'd0);
    cyc();
    ret_chk("coll2", 8'd7, 40'd100, 40'd60, 1'b0);
    chk("coll2.outst", 64'(outstanding), 64'd0);
    chk("coll2.sum", 64'(stat_sum), 64'd395);
    chk("coll2.count", 64'(stat_count), 64'd5);

    // Back-to-back returns to the same tag: second is an orphan
    stamp(8'd2, 40'd10);
    ret_valid = 1'b1; ret_tag = 8'd2; latency_counter = 40'd20;
    cyc();
    latency_counter = 40'd21;
    cyc();
    ret_valid = 1'b0;
    chk("b2b.first_value", 64'(lat_value), 64'd10);
    chk("b2b.first_orphan", 64'(lat_orphan), 64'd0);
    cyc();
    chk("b2b.second_valid", 64'(lat_valid), 64'd1);
    chk("b2b.second_orphan", 64'(lat_orphan), 64'd1);
    chk("b2b.second_value", 64'(lat_value), 64'd0);
    cyc();
    chk("b2b.orphan_cnt", 64'(orphan_cnt), 64'd2);

    // Clear before streaming
    stats_clear = 1'b1;
    cyc();
    stats_clear = 1'b0;
    chk("clr0.count", 64'(stat_count), 64'd0);
    chk("clr0.min", 64'(stat_min), 64'(MIN_RST));
    chk("clr0.dup", 64'(dup_cnt), 64'd0);
    chk("clr0.orphan", 64'(orphan_cnt), 64'd0);

    // Streaming: stamp tag i at i, return tag i at 2i+1 -> latency i+1
    for (int i = 0; i < 256; i++) begin
      stamp_valid = 1'b1; stamp_tag = 8'(i); latency_counter = 40'(i);
      cyc();
    end
    stamp_valid = 1'b0;
    chk("stream.outst_full", 64'(outstanding), 64'd256);
    pulses = 0;
    for (int c = 0; c < 258; c++) begin
      if (c < 256) begin
        ret_valid = 1'b1; ret_tag = 8'(c); latency_counter = 40'(2 * c + 1);
      end else begin
        ret_valid = 1'b0;
      end
      cyc();
      if (lat_valid) pulses++;
      if (c >= 1 && c <= 256) begin
        chk("stream.valid", 64'(lat_valid), 64'd1);
        chk("stream.value", 64'(lat_value), 64'(c));
      end
    end
    chk("stream.pulses", 64'(pulses), 64'd256);
    chk("stream.tail_idle", 64'(lat_valid), 64'd0);
    chk("stream.count", 64'(stat_count), 64'd256);
    chk("stream.min", 64'(stat_min), 64'd1);
    chk("stream.max", 64'(stat_max), 64'd256);
    chk("stream.sum", 64'(stat_sum), 64'd32896);
    chk("stream.outst", 64'(outstanding), 64'd0);

    // Clear with 3 pending tags and a same-cycle stamp on tag 20
    stamp(8'd10, 40'd100);
    stamp(8'd11, 40'd100);
    stamp(8'd12, 40'd100);
    chk("clr.outst_pre", 64'(outstanding), 64'd3);
    stats_clear = 1'b1; stamp_valid = 1'b1; stamp_tag = 8'd20; latency_counter = 40'd500;
    cyc();
    stats_clear = 1'b0; stamp_valid = 1'b0;
    chk("clr.outst", 64'(outstanding), 64'd1);
    chk("clr.count", 64'(stat_count), 64'd0);
    chk("clr.sum", 64'(stat_sum), 64'd0);
    chk("clr.min", 64'(stat_min), 64'(MIN_RST));
    chk("clr.max", 64'(stat_max), 64'd0);
    ret_chk("clr.ret10", 8'd10, 40'd200, 40'd0, 1'b1);
    chk("clr.orphan_cnt", 64'(orphan_cnt), 64'd1);

    // Result presented in a clear cycle is emitted but not accumulated
    ret_valid = 1'b1; ret_tag = 8'd20; latency_counter = 40'd600;
    cyc();
    ret_valid = 1'b0;
    cyc();
    chk("clrres.valid", 64'(lat_valid), 64'd1);
    chk("clrres.value", 64'(lat_value), 64'd100);
    stats_clear = 1'b1;
    cyc();
    stats_clear = 1'b0;
    chk("clrres.count", 64'(stat_count), 64'd0);
    chk("clrres.max", 64'(stat_max), 64'd0);

    // Async reset mid-pipeline
    stamp(8'd30, 40'd0);
    stamp(8'd31, 40'd0);
    ret_valid = 1'b1; ret_tag = 8'd30; latency_counter = 40'd10;
    cyc();
    ret_tag = 8'd31;
    cyc();
    ret_valid = 1'b0;
    chk("rstmid.pre_valid", 64'(lat_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.valid_now", 64'(lat_valid), 64'd0);
    chk("rstmid.outst", 64'(outstanding), 64'd0);
    cyc();
    #3;
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      cyc();
      if (lat_valid) pulses++;
    end
    chk("rstmid.no_pulse", 64'(pulses), 64'd0);
    chk("rstmid.min", 64'(stat_min), 64'(MIN_RST));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
